// File: rtl/mem_stage_if.sv
// mem_stage_if -- EX-to-MEM inputs and MEM/WB outputs of the memory stage.
// Optional feature macro: MEM_MISALIGN_TRAP_EN adds the misaligned flag.
interface mem_stage_if;
    // Pipeline control from the hazard unit
    logic        stall;
    logic        flush;

    // EX-stage outputs
    logic        in_valid;
    logic        RegWrite;
    logic        MemToReg;
    logic        MemRead;
    logic        MemWrite;
    logic        Branch;
    logic        zero;
    logic [31:0] proxdir_result;
    logic [31:0] ALU_result;
    logic [31:0] DR2;
    logic [4:0]  WriteRegister;

    // Branch resolution towards fetch
    logic        PCSrc;
    logic [31:0] branch_target;

    // MEM/WB register
    logic        wb_valid;
    logic        wb_RegWrite;
    logic        wb_MemToReg;
    logic [31:0] wb_read_data;
    logic [31:0] wb_alu_result;
    logic [4:0]  wb_WriteRegister;

`ifdef MEM_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    // Upstream pipeline / test driver side
    modport master (
        output stall, flush, in_valid, RegWrite, MemToReg, MemRead, MemWrite,
               Branch, zero, proxdir_result, ALU_result, DR2, WriteRegister,
        input  PCSrc, branch_target, wb_valid, wb_RegWrite, wb_MemToReg,
               wb_read_data, wb_alu_result, wb_WriteRegister
`ifdef MEM_MISALIGN_TRAP_EN
        , input misaligned
`endif
    );

    // Memory stage side
    modport slave (
        input  stall, flush, in_valid, RegWrite, MemToReg, MemRead, MemWrite,
               Branch, zero, proxdir_result, ALU_result, DR2, WriteRegister,
        output PCSrc, branch_target, wb_valid, wb_RegWrite, wb_MemToReg,
               wb_read_data, wb_alu_result, wb_WriteRegister
`ifdef MEM_MISALIGN_TRAP_EN
        , output misaligned
`endif
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage -- EX/MEM register, word-addressed data memory, MEM/WB register.
// Loads read asynchronously from the EX/MEM address; stores commit on the
// clock edge that moves the instruction into MEM/WB.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (trap unaligned accesses).
module mem_stage #(
    parameter int MEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        zero;
        logic [31:0] target;
        logic [31:0] alu;
        logic [31:0] dr2;
        logic [4:0]  wreg;
    } exmem_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] read_data;
        logic [31:0] alu;
        logic [4:0]  wreg;
    } memwb_t;

    exmem_t           exmem;
    memwb_t           memwb;
    logic [31:0]      mem [MEM_DEPTH];
    logic [IDX_W-1:0] idx;
    logic [31:0]      rd_value;
    logic             access_ok;
    logic             wr_en;

    // EX/MEM register: flush inserts a bubble and wins over stall
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (reset) begin
            exmem <= '0;
        end else if (bus.flush) begin
            exmem.valid      <= 1'b0;
            exmem.reg_write  <= 1'b0;
            exmem.mem_to_reg <= 1'b0;
            exmem.mem_read   <= 1'b0;
            exmem.mem_write  <= 1'b0;
            exmem.branch     <= 1'b0;
            exmem.zero       <= 1'b0;
        end else if (!bus.stall) begin
            exmem <= '{valid:      bus.in_valid,
                       reg_write:  bus.RegWrite,
                       mem_to_reg: bus.MemToReg,
                       mem_read:   bus.MemRead,
                       mem_write:  bus.MemWrite,
                       branch:     bus.Branch,
                       zero:       bus.zero,
                       target:     bus.proxdir_result,
                       alu:        bus.ALU_result,
                       dr2:        bus.DR2,
                       wreg:       bus.WriteRegister};
        end
    end

    // Word index wraps modulo MEM_DEPTH; byte-offset bits are not part of it
    assign idx = exmem.alu[IDX_W+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign bus.misaligned = exmem.valid & (exmem.mem_read | exmem.mem_write)
                          & (exmem.alu[1:0] != 2'b00);
    assign access_ok      = ~bus.misaligned;
`else
    assign access_ok      = 1'b1;
`endif

    // A store commits only for a live, non-stalled, well-formed instruction
    assign wr_en    = exmem.valid & exmem.mem_write & ~bus.stall & access_ok;

    // Asynchronous read: a same-cycle store sees the pre-write word
    assign rd_value = (exmem.mem_read & access_ok) ? mem[idx] : 32'h0;

    // Data memory write port
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately left out of reset; its contents
        // survive reset and it maps onto plain RAM without a clear path.
        if (wr_en) begin
            mem[idx] <= exmem.dr2;
        end
    end

    // MEM/WB register: advances on every non-stalled edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memwb <= '0;
        end else if (!bus.stall) begin
            memwb <= '{valid:      exmem.valid,
                       reg_write:  exmem.valid & exmem.reg_write,
                       mem_to_reg: exmem.mem_to_reg,
                       read_data:  rd_value,
                       alu:        exmem.alu,
                       wreg:       exmem.wreg};
        end
    end

    // Branch resolves from the EX/MEM register contents
    assign bus.PCSrc            = exmem.valid & exmem.branch & exmem.zero;
    assign bus.branch_target    = exmem.target;

    assign bus.wb_valid         = memwb.valid;
    assign bus.wb_RegWrite      = memwb.reg_write;
    assign bus.wb_MemToReg      = memwb.mem_to_reg;
    assign bus.wb_read_data     = memwb.read_data;
    assign bus.wb_alu_result    = memwb.alu;
    assign bus.wb_WriteRegister = memwb.wreg;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- self-checking bench for mem_stage (MEM_DEPTH = 64).
// Honours MEM_MISALIGN_TRAP_EN when defined for the build.
module tb_mem_stage;
    localparam int DEPTH = 64;

    typedef struct {
        bit        valid, rw, m2r, mr, mw, br, zero;
        bit [31:0] target, alu, dr2;
        bit [4:0]  wreg;
    } instr_t;

    typedef struct {
        bit        valid, rw, m2r;
        bit [31:0] rd, alu;
        bit [4:0]  wreg;
    } wb_t;

    typedef struct {
        bit        valid, br, zero;
        bit [31:0] target;
        bit        exp_pcsrc;
        bit [31:0] exp_target;
    } br_vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    // Reference model: the instruction sitting between EX and MEM, the
    // result last handed to writeback, and the word array.
    instr_t    m_ex;
    bit        m_ex_known;
    wb_t       m_wb;
    bit        m_wb_known;
    bit [31:0] m_mem [DEPTH];

    mem_stage_if bus ();

    mem_stage #(.MEM_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mis_m(input instr_t i);
`ifdef MEM_MISALIGN_TRAP_EN
        return i.valid && (i.mr || i.mw) && (i.alu % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic instr_t nop();
        instr_t i;
        i = '{default: 0};
        return i;
    endfunction

    function automatic instr_t store(input bit [31:0] addr, input bit [31:0] data);
        instr_t i;
        i = nop();
        i.valid = 1; i.mw = 1; i.alu = addr; i.dr2 = data;
        return i;
    endfunction

    function automatic instr_t load(input bit [31:0] addr, input bit [4:0] rd);
        instr_t i;
        i = nop();
        i.valid = 1; i.mr = 1; i.rw = 1; i.m2r = 1; i.alu = addr; i.wreg = rd;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.valid  = ($urandom_range(0, 4) != 0);
        i.rw     = $urandom_range(0, 1) != 0;
        i.m2r    = $urandom_range(0, 1) != 0;
        i.mr     = $urandom_range(0, 1) != 0;
        i.mw     = $urandom_range(0, 2) == 0;
        i.br     = $urandom_range(0, 2) == 0;
        i.zero   = $urandom_range(0, 1) != 0;
        i.target = $urandom;
        i.alu    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
        i.dr2    = $urandom;
        i.wreg   = 5'($urandom);
        return i;
    endfunction

    task automatic drive(input instr_t i, input bit st, input bit fl);
        bus.stall          = st;
        bus.flush          = fl;
        bus.in_valid       = i.valid;
        bus.RegWrite       = i.rw;
        bus.MemToReg       = i.m2r;
        bus.MemRead        = i.mr;
        bus.MemWrite       = i.mw;
        bus.Branch         = i.br;
        bus.zero           = i.zero;
        bus.proxdir_result = i.target;
        bus.ALU_result     = i.alu;
        bus.DR2            = i.dr2;
        bus.WriteRegister  = i.wreg;
    endtask

    task automatic model_reset();
        m_ex       = nop();
        m_ex_known = 1;
        m_wb       = '{default: 0};
        m_wb_known = 1;
    endtask

    // Compare every output against the model
    task automatic compare_all();
        check("PCSrc", bus.PCSrc, m_ex.valid && m_ex.br && m_ex.zero);
        if (m_ex_known) check("branch_target", bus.branch_target, m_ex.target);
        check("wb_valid", bus.wb_valid, m_wb.valid);
        check("wb_RegWrite", bus.wb_RegWrite, m_wb.rw);
        check("wb_MemToReg", bus.wb_MemToReg, m_wb.m2r);
        check("wb_read_data", bus.wb_read_data, m_wb.rd);
        if (m_wb_known) begin
            check("wb_alu_result", bus.wb_alu_result, m_wb.alu);
            check("wb_WriteRegister", bus.wb_WriteRegister, m_wb.wreg);
        end
`ifdef MEM_MISALIGN_TRAP_EN
        check("misaligned", bus.misaligned, mis_m(m_ex));
`endif
    endtask

    // One clock: present inputs, advance the model, sample 1 ns after the edge
    task automatic cycle(input instr_t i, input bit st, input bit fl);
        int idx;
        bit mis;
        drive(i, st, fl);
        if (!st) begin
            mis = mis_m(m_ex);
            idx = int'((m_ex.alu / 4) % DEPTH);
            m_wb.valid = m_ex.valid;
            m_wb.rw    = m_ex.valid && m_ex.rw;
            m_wb.m2r   = m_ex.m2r;
            m_wb.rd    = (m_ex.mr && !mis) ? m_mem[idx] : 32'h0;
            m_wb.alu   = m_ex.alu;
            m_wb.wreg  = m_ex.wreg;
            m_wb_known = m_ex_known;
            if (m_ex.valid && m_ex.mw && !mis) m_mem[idx] = m_ex.dr2;
        end
        if (fl) begin
            m_ex.valid = 0; m_ex.rw = 0; m_ex.m2r = 0; m_ex.mr = 0;
            m_ex.mw = 0; m_ex.br = 0; m_ex.zero = 0;
            m_ex_known = 0;
        end else if (!st) begin
            m_ex       = i;
            m_ex_known = 1;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        br_vec_t   vecs [5];
        instr_t    br_i;
        bit [31:0] saved;

        checks   = 0;
        failures = 0;

        vecs[0] = '{valid: 1, br: 1, zero: 1, target: 32'h0000_0040, exp_pcsrc: 1, exp_target: 32'h0000_0040};
        vecs[1] = '{valid: 1, br: 1, zero: 0, target: 32'h0000_0040, exp_pcsrc: 0, exp_target: 32'h0000_0040};
        vecs[2] = '{valid: 0, br: 1, zero: 1, target: 32'h0000_0080, exp_pcsrc: 0, exp_target: 32'h0000_0080};
        vecs[3] = '{valid: 1, br: 0, zero: 1, target: 32'h0000_0044, exp_pcsrc: 0, exp_target: 32'h0000_0044};
        vecs[4] = '{valid: 1, br: 1, zero: 1, target: 32'hFFFF_FFFC, exp_pcsrc: 1, exp_target: 32'hFFFF_FFFC};

        // Reset state
        reset = 1'b1;
        drive(nop(), 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;

        // Give every word a known value through the store path
        for (int k = 0; k < DEPTH; k++) cycle(store(32'(k * 4), $urandom), 0, 0);
        cycle(nop(), 0, 0);
        cycle(nop(), 0, 0);

        // Branch resolution table
        for (int v = 0; v < 5; v++) begin
            br_i        = nop();
            br_i.valid  = vecs[v].valid;
            br_i.br     = vecs[v].br;
            br_i.zero   = vecs[v].zero;
            br_i.target = vecs[v].target;
            cycle(br_i, 0, 0);
            check("tbl_PCSrc", bus.PCSrc, vecs[v].exp_pcsrc);
            check("tbl_branch_target", bus.branch_target, vecs[v].exp_target);
        end

        // Store then load of the same word in back-to-back instructions
        cycle(store(32'h10, 32'hDEAD_BEEF), 0, 0);
        cycle(load(32'h10, 5'd3), 0, 0);
        cycle(nop(), 0, 0);
        check("st_ld_data", bus.wb_read_data, 32'hDEAD_BEEF);
        check("st_ld_wreg", bus.wb_WriteRegister, 32'd3);

        // Read and write of one word in the same instruction
        cycle(store(32'h20, 32'hAAAA_5555), 0, 0);
        br_i     = load(32'h20, 5'd9);
        br_i.mw  = 1;
        br_i.dr2 = 32'h1111_2222;
        cycle(br_i, 0, 0);
        cycle(load(32'h20, 5'd10), 0, 0);
        check("rmw_old_word", bus.wb_read_data, 32'hAAAA_5555);
        cycle(nop(), 0, 0);
        check("rmw_new_word", bus.wb_read_data, 32'h1111_2222);

        // Stalled store: no write while stall is held
        cycle(store(32'h10, 32'h5A5A_0001), 0, 0);
        for (int s = 0; s < 3; s++) begin
            cycle(load(32'h3C, 5'd1), 1, 0);
            check("stall_no_write", dut.mem[4], 32'hDEAD_BEEF);
        end
        cycle(nop(), 0, 0);
        check("stall_release_write", dut.mem[4], 32'h5A5A_0001);

        // Flushed store never reaches memory
        saved = m_mem[8];
        cycle(store(32'h20, 32'hBADB_AD00), 0, 1);
        cycle(nop(), 0, 0);
        check("flush_wb_valid", bus.wb_valid, 32'd0);
        check("flush_no_write", dut.mem[8], saved);

        // Address wrap modulo depth
        cycle(store(32'h104, 32'hC0FF_EE01), 0, 0);
        cycle(load(32'h004, 5'd4), 0, 0);
        cycle(nop(), 0, 0);
        check("wrap_load", bus.wb_read_data, 32'hC0FF_EE01);

`ifdef MEM_MISALIGN_TRAP_EN
        // Unaligned store traps and does not write
        saved = m_mem[4];
        cycle(store(32'h12, 32'h0BAD_0BAD), 0, 0);
        check("misaligned_flag", bus.misaligned, 32'd1);
        cycle(nop(), 0, 0);
        check("misaligned_no_write", dut.mem[4], saved);
`endif

        // Asynchronous reset with the pipeline full
        br_i        = nop();
        br_i.valid  = 1; br_i.br = 1; br_i.zero = 1; br_i.target = 32'h40;
        cycle(br_i, 0, 0);
        cycle(load(32'h10, 5'd7), 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("rst_PCSrc", bus.PCSrc, 32'd0);
        check("rst_branch_target", bus.branch_target, 32'd0);
        check("rst_wb_valid", bus.wb_valid, 32'd0);
        check("rst_wb_RegWrite", bus.wb_RegWrite, 32'd0);
        check("rst_wb_alu_result", bus.wb_alu_result, 32'd0);
        check("rst_wb_WriteRegister", bus.wb_WriteRegister, 32'd0);
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset before the write edge cancels the store; memory survives reset
        saved = m_mem[12];
        cycle(store(32'h30, 32'h7777_0000), 0, 0);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        drive(nop(), 0, 0);
        check("rst_store_cancel", dut.mem[12], saved);
        cycle(load(32'h10, 5'd2), 0, 0);
        cycle(nop(), 0, 0);
        check("mem_kept_over_reset", bus.wb_read_data, 32'h5A5A_0001);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            cycle(rand_instr(), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter MEM_DEPTH, default 64, data memory depth in 32-bit words, power of two, 4..1024.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  hold both pipeline registers; suppress memory write.
REQ-005 flush  input  1  load bubble into EX/MEM register.
REQ-006 in_valid  input  1  EX-stage outputs carry a real instruction.
REQ-007 RegWrite, MemToReg, MemRead, MemWrite, Branch  input  1 each  control bits travelling with the instruction.
REQ-008 zero  input  1  ALU zero flag from EX.
REQ-009 proxdir_result  input  32  branch target computed in EX.
REQ-010 ALU_result  input  32  ALU result / effective address.
REQ-011 DR2  input  32  store data (register rt value).
REQ-012 WriteRegister  input  5  destination register from RegDst mux.
REQ-013 PCSrc  output  1  branch taken, to fetch stage.
REQ-014 branch_target  output  32  registered proxdir_result.
REQ-015 wb_valid, wb_RegWrite, wb_MemToReg  output  1 each  MEM/WB control.
REQ-016 wb_read_data, wb_alu_result  output  32 each  MEM/WB data.
REQ-017 wb_WriteRegister  output  5  MEM/WB destination register.
REQ-018 misaligned  output  1  present only with MEM_MISALIGN_TRAP_EN.

Function
REQ-019 EX/MEM register SHALL capture all inputs on rising edge when stall=0 and flush=0.
REQ-020 flush=1 SHALL load EX/MEM with valid=0 and all control bits 0, regardless of stall; data fields don't-care.
REQ-021 stall=1, flush=0 SHALL hold EX/MEM and MEM/WB unchanged.
REQ-022 PCSrc SHALL equal exmem_valid & exmem_Branch & exmem_zero, combinational from EX/MEM register.
REQ-023 Word index SHALL be exmem_ALU_result[log2(MEM_DEPTH)+1:2]; upper bits ignored (wrap modulo MEM_DEPTH).
REQ-024 Memory write SHALL occur at rising edge when exmem_valid & exmem_MemWrite & !stall, writing exmem_DR2.
REQ-025 Memory read SHALL be asynchronous from current index; MEM/WB captures read value if exmem_MemRead else 0.
REQ-026 MEM/WB SHALL capture exmem valid, RegWrite (gated by valid), MemToReg, ALU_result, WriteRegister on each non-stalled edge.
REQ-027 Latency SHALL be 2 edges from EX inputs to wb_* outputs; PCSrc valid 1 edge after capture.
REQ-028 Store followed by load to same word in next instruction SHALL return the stored value.
REQ-029 Simultaneous MemRead and MemWrite SHALL return the pre-write word to MEM/WB and write new data.

Reset
REQ-030 reset SHALL clear immediately, independent of clk: all EX/MEM and MEM/WB fields, PCSrc=0, branch_target=0, all wb_* = 0, misaligned=0.
REQ-031 Memory array contents SHALL NOT be cleared by reset.
REQ-032 reset asserted mid-store SHALL suppress that store if asserted before the write edge.

Configuration
REQ-033 Macro MEM_MISALIGN_TRAP_EN defined: misaligned = exmem_valid & (MemRead|MemWrite) & (ALU_result[1:0]!=0), combinational; such store SHALL NOT write; such load SHALL yield wb_read_data=0.
REQ-034 Macro undefined: misaligned port absent; address bits [1:0] ignored, access proceeds on aligned word.

Verification
REQ-035 Store DR2=0xDEADBEEF addr 0x10, then load addr 0x10 next cycle -> wb_read_data=0xDEADBEEF two edges after load.
REQ-036 Branch=1, zero=1, proxdir_result=0x40 -> PCSrc=1, branch_target=0x40 after one edge; zero=0 -> PCSrc=0.
REQ-037 Store at addr 0x10 with stall=1 held 3 cycles -> no write until stall drops; wb_* unchanged during stall.
REQ-038 flush=1 with MemWrite=1 addr 0x20 -> memory word 8 unchanged, wb_valid=0 after two edges.
REQ-039 Assert reset between edges with pipeline full -> all outputs 0 immediately, before next clk edge.
REQ-040 MEM_DEPTH=64, store to 0x104 -> load 0x004 returns same data; with macro, store to 0x12 -> misaligned=1, no write.
